// File: rtl/escalonador_elevador.sv
// SCAN stop scheduler for a single elevator car: latches floor requests, picks the next
// destination in the travel direction, stops at pending floors on the way, times moves and doors.
module escalonador_elevador #(
    parameter int N_FLOORS    = 16,
    parameter int FLOOR_W     = 4,
    parameter int FLOOR_TICKS = 8,
    parameter int DOOR_TICKS  = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                iniciar,
    input  logic                req_valid,
    input  logic [FLOOR_W-1:0]  req_floor,
    output logic [FLOOR_W-1:0]  andar_atual,
    output logic [FLOOR_W-1:0]  destino,
    output logic                sobe,
    output logic                desce,
    output logic                porta_aberta,
    output logic [N_FLOORS-1:0] pendentes,
    output logic                ocupado,
    output logic [2:0]          estado
);

    // Handshake: req_valid is a one-cycle strobe with no back-pressure; every
    // request is either latched into pendentes on that edge or dropped.

    typedef enum logic [2:0] {
        INATIVO = 3'd0,
        OCIOSO  = 3'd1,
        ESCOLHE = 3'd2,
        MOVE    = 3'd3,
        PORTA   = 3'd4
    } estado_t;

    localparam int TICK_MAX = (FLOOR_TICKS > DOOR_TICKS) ? FLOOR_TICKS : DOOR_TICKS;
    localparam int TICK_W   = $clog2(TICK_MAX) + 1;
    localparam logic [TICK_W-1:0] FLOOR_LOAD = TICK_W'(FLOOR_TICKS - 1);
    localparam logic [TICK_W-1:0] DOOR_LOAD  = TICK_W'(DOOR_TICKS - 1);

    estado_t             st;
    logic                dir_up;
    logic [TICK_W-1:0]   tick;

    logic                above_ok, below_ok;
    logic [FLOOR_W-1:0]  above_idx, below_idx;
    logic                at_bottom, at_top, dir_eff, go_up, here_pending, at_limit;
    logic [FLOOR_W-1:0]  next_floor;
    logic [N_FLOORS-1:0] set_mask, clr_mask;

    assign estado = st;

    // Nearest pending floor strictly above (lowest index) and strictly below (highest index).
    always_comb begin
        above_ok  = 1'b0;
        above_idx = '0;
        below_ok  = 1'b0;
        below_idx = '0;
        for (int i = N_FLOORS - 1; i >= 0; i--) begin
            if (pendentes[i] && i > int'(andar_atual)) begin
                above_ok  = 1'b1;
                above_idx = FLOOR_W'(i);
            end
        end
        for (int i = 0; i < N_FLOORS; i++) begin
            if (pendentes[i] && i < int'(andar_atual)) begin
                below_ok  = 1'b1;
                below_idx = FLOOR_W'(i);
            end
        end
    end

    always_comb begin
        at_bottom    = (andar_atual == '0);
        at_top       = (int'(andar_atual) == N_FLOORS - 1);
        dir_eff      = at_bottom ? 1'b1 : (at_top ? 1'b0 : dir_up);
        go_up        = dir_eff ? above_ok : !below_ok;
        here_pending = pendentes[andar_atual];
        at_limit     = dir_up ? at_top : at_bottom;
        next_floor   = dir_up ? (andar_atual + FLOOR_W'(1)) : (andar_atual - FLOOR_W'(1));

        set_mask = '0;
        if (req_valid && int'(req_floor) < N_FLOORS && st != INATIVO &&
            !(st == PORTA && req_floor == andar_atual))
            set_mask[req_floor] = 1'b1;

        // The bit of the floor whose door is opening is cleared on the entry edge.
        clr_mask = '0;
        if (st == ESCOLHE && here_pending)
            clr_mask[andar_atual] = 1'b1;
        if (st == MOVE && tick == '0 && !at_limit && pendentes[next_floor])
            clr_mask[next_floor] = 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            st           <= INATIVO;
            andar_atual  <= '0;
            destino      <= '0;
            dir_up       <= 1'b1;
            pendentes    <= '0;
            tick         <= '0;
            sobe         <= 1'b0;
            desce        <= 1'b0;
            porta_aberta <= 1'b0;
            ocupado      <= 1'b0;
        end else begin
            pendentes <= (pendentes | set_mask) & ~clr_mask;
            case (st)
                INATIVO: begin
                    if (iniciar)
                        st <= OCIOSO;
                end
                OCIOSO: begin
                    if (|pendentes) begin
                        st      <= ESCOLHE;
                        ocupado <= 1'b1;
                    end
                end
                ESCOLHE: begin
                    if (here_pending) begin
                        st           <= PORTA;
                        destino      <= andar_atual;
                        porta_aberta <= 1'b1;
                        tick         <= DOOR_LOAD;
                    end else begin
                        st      <= MOVE;
                        dir_up  <= go_up;
                        destino <= go_up ? above_idx : below_idx;
                        sobe    <= go_up;
                        desce   <= !go_up;
                        tick    <= FLOOR_LOAD;
                    end
                end
                MOVE: begin
                    if (tick != '0) begin
                        tick <= tick - TICK_W'(1);
                    end else if (at_limit) begin
                        // Unreachable while the destination stays pending; parks the car safely.
                        st      <= OCIOSO;
                        sobe    <= 1'b0;
                        desce   <= 1'b0;
                        ocupado <= 1'b0;
                    end else begin
                        andar_atual <= next_floor;
                        tick        <= FLOOR_LOAD;
                        if (pendentes[next_floor]) begin
                            st           <= PORTA;
                            sobe         <= 1'b0;
                            desce        <= 1'b0;
                            porta_aberta <= 1'b1;
                            tick         <= DOOR_LOAD;
                        end
                    end
                end
                PORTA: begin
                    if (tick != '0) begin
                        tick <= tick - TICK_W'(1);
                    end else begin
                        st           <= OCIOSO;
                        porta_aberta <= 1'b0;
                        ocupado      <= 1'b0;
                    end
                end
                default: st <= INATIVO;
            endcase
        end
    end

endmodule

// File: tb/tb_escalonador_elevador.sv
// Directed bench for escalonador_elevador: expected stop floors are queued when requests are
// issued; a negedge monitor pops one per door opening and checks door length and motor exclusivity.
module tb_escalonador_elevador;

    localparam int N_FLOORS    = 10;
    localparam int FLOOR_W     = 4;
    localparam int FLOOR_TICKS = 8;
    localparam int DOOR_TICKS  = 4;

    localparam int S_INATIVO = 0;
    localparam int S_OCIOSO  = 1;
    localparam int S_ESCOLHE = 2;

    logic                clock = 1'b0;
    logic                reset = 1'b1;
    logic                iniciar = 1'b0;
    logic                req_valid = 1'b0;
    logic [FLOOR_W-1:0]  req_floor = '0;
    logic [FLOOR_W-1:0]  andar_atual, destino;
    logic                sobe, desce, porta_aberta, ocupado;
    logic [N_FLOORS-1:0] pendentes;
    logic [2:0]          estado;

    int total = 0;
    int bad   = 0;
    logic [FLOOR_W-1:0] exp_q[$];
    logic [FLOOR_W-1:0] exp_floor;
    int sobe_cnt  = 0;
    int desce_cnt = 0;
    int door_len  = 0;
    logic porta_prev = 1'b0;
    int s0, d0;

    escalonador_elevador #(
        .N_FLOORS(N_FLOORS), .FLOOR_W(FLOOR_W),
        .FLOOR_TICKS(FLOOR_TICKS), .DOOR_TICKS(DOOR_TICKS)
    ) dut (
        .clock(clock), .reset(reset), .iniciar(iniciar),
        .req_valid(req_valid), .req_floor(req_floor),
        .andar_atual(andar_atual), .destino(destino),
        .sobe(sobe), .desce(desce), .porta_aberta(porta_aberta),
        .pendentes(pendentes), .ocupado(ocupado), .estado(estado)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: one expected floor per door opening, fixed door length, never both motor lines.
    always @(negedge clock) begin
        if (sobe)  sobe_cnt++;
        if (desce) desce_cnt++;
        check("sobe_desce_exclusive", int'(sobe && desce), 0);
        if (porta_aberta && !porta_prev) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL stop_unexpected: got floor %0d expected no stop", andar_atual);
            end else begin
                exp_floor = exp_q.pop_front();
                check("stop_floor", int'(andar_atual), int'(exp_floor));
            end
        end
        if (porta_aberta) begin
            door_len++;
        end else if (porta_prev) begin
            check("door_len", door_len, DOOR_TICKS);
            door_len = 0;
        end
        porta_prev = porta_aberta;
    end

    task automatic send_req(input int f);
        req_valid = 1'b1;
        req_floor = FLOOR_W'(f);
        @(negedge clock);
        req_valid = 1'b0;
    endtask

    task automatic pulse_iniciar();
        iniciar = 1'b1;
        @(negedge clock);
        iniciar = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int max_cycles);
        int n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!(int'(estado) == S_OCIOSO && pendentes == '0 && !porta_aberta) && n < max_cycles);
        check(name, int'(n < max_cycles), 1);
    endtask

    task automatic wait_floor(input string name, input int f, input int max_cycles);
        int n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (int'(andar_atual) != f && n < max_cycles);
        check(name, int'(n < max_cycles), 1);
    endtask

    initial begin
        // Reset values while reset is held
        repeat (2) @(negedge clock);
        check("rst_andar", int'(andar_atual), 0);
        check("rst_destino", int'(destino), 0);
        check("rst_motor", int'({sobe, desce}), 0);
        check("rst_porta", int'(porta_aberta), 0);
        check("rst_pendentes", int'(pendentes), 0);
        check("rst_ocupado", int'(ocupado), 0);
        check("rst_estado", int'(estado), S_INATIVO);
        reset = 1'b0;
        @(negedge clock);

        // Requests are dropped before iniciar
        send_req(3);
        check("inativo_ignores_req", int'(pendentes), 0);
        pulse_iniciar();
        check("iniciar_to_ocioso", int'(estado), S_OCIOSO);

        // T1: 0 -> 3, three floors of sobe
        s0 = sobe_cnt; d0 = desce_cnt;
        exp_q.push_back(3);
        send_req(3);
        wait_idle("t1_timeout", 300);
        check("t1_sobe_cycles", sobe_cnt - s0, 3 * FLOOR_TICKS);
        check("t1_desce_cycles", desce_cnt - d0, 0);
        check("t1_andar", int'(andar_atual), 3);
        check("t1_destino", int'(destino), 3);
        check("t1_pendentes", int'(pendentes), 0);

        // T2: 3 -> 8, request 6 issued at floor 4 is served on the way
        s0 = sobe_cnt;
        exp_q.push_back(6);
        exp_q.push_back(8);
        send_req(8);
        wait_floor("t2_reach4_timeout", 4, 100);
        send_req(6);
        wait_idle("t2_timeout", 300);
        check("t2_sobe_cycles", sobe_cnt - s0, 5 * FLOOR_TICKS);
        check("t2_andar", int'(andar_atual), 8);
        check("t2_destino", int'(destino), 8);

        // T3: at 8 going up, pending {2,9}: 9 first, then reverse to 2
        s0 = sobe_cnt; d0 = desce_cnt;
        exp_q.push_back(9);
        exp_q.push_back(2);
        send_req(2);
        send_req(9);
        wait_idle("t3_timeout", 300);
        check("t3_sobe_cycles", sobe_cnt - s0, 1 * FLOOR_TICKS);
        check("t3_desce_cycles", desce_cnt - d0, 7 * FLOOR_TICKS);
        check("t3_andar", int'(andar_atual), 2);
        check("t3_destino", int'(destino), 2);

        // T4: request for the idle car's own floor, then re-request while the door is open
        s0 = sobe_cnt; d0 = desce_cnt;
        exp_q.push_back(2);
        send_req(2);
        check("t4_pend_latched", int'(pendentes), 4);
        check("t4_k_ocupado", int'(ocupado), 0);
        @(negedge clock);
        check("t4_k1_estado", int'(estado), S_ESCOLHE);
        check("t4_k1_ocupado", int'(ocupado), 1);
        check("t4_k1_porta", int'(porta_aberta), 0);
        @(negedge clock);
        check("t4_k2_porta", int'(porta_aberta), 1);
        check("t4_k2_pend_cleared", int'(pendentes), 0);
        send_req(2);
        check("t4_porta_req_ignored", int'(pendentes), 0);
        wait_idle("t4_timeout", 50);
        repeat (4) @(negedge clock);
        check("t4_no_reopen", int'(ocupado), 0);
        check("t4_motor_idle", (sobe_cnt - s0) + (desce_cnt - d0), 0);

        // T5: out-of-range floor is ignored
        send_req(15);
        repeat (2) @(negedge clock);
        check("t5_oob_pendentes", int'(pendentes), 0);
        check("t5_oob_estado", int'(estado), S_OCIOSO);

        // T6: asynchronous reset while moving at floor 3
        send_req(9);
        wait_floor("t6_reach3_timeout", 3, 100);
        check("t6_moving", int'(sobe), 1);
        #2 reset = 1'b1;
        #1;
        check("t6_async_sobe", int'(sobe), 0);
        check("t6_async_andar", int'(andar_atual), 0);
        check("t6_async_pendentes", int'(pendentes), 0);
        check("t6_async_estado", int'(estado), S_INATIVO);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        send_req(4);
        check("t6_inativo_ignores", int'(pendentes), 0);
        pulse_iniciar();
        s0 = sobe_cnt;
        exp_q.push_back(1);
        send_req(1);
        wait_idle("t6_restart_timeout", 100);
        check("t6_restart_andar", int'(andar_atual), 1);
        check("t6_restart_sobe", sobe_cnt - s0, FLOOR_TICKS);
        check("queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
